// File: rtl/inst_bus_arbiter_pkg.sv
// Shared defines for the instruction-bus arbiter: bus widths, constants
// and the response-owner encoding.
package inst_bus_arbiter_pkg;

   localparam int unsigned InstAddrBus  = 32;
   localparam int unsigned InstBus      = 32;
   localparam logic [31:0] ZeroWord     = 32'h0000_0000;
   localparam logic        ChipEnable   = 1'b1;
   localparam logic        ChipDisable  = 1'b0;
   localparam logic        RstEnable    = 1'b1;
   localparam int unsigned DbgStarveLim = 4;

   typedef enum logic [1:0] {
      RspNone = 2'b00,
      RspIf   = 2'b01,
      RspDbg  = 2'b10
   } rsp_owner_e;

endpackage

// File: rtl/inst_bus_arbiter.sv
// Arbitrates the single-ported instruction memory between the fetch path
// (default priority) and the debug/loader port, with starvation protection.
module inst_bus_arbiter
   import inst_bus_arbiter_pkg::*;
#(
   parameter int unsigned ADDR_W     = InstAddrBus,
   parameter int unsigned DATA_W     = InstBus,
   parameter int unsigned STARVE_LIM = DbgStarveLim
) (
   input  logic              clk,
   input  logic              rst,
   input  logic              if_ce,
   input  logic [ADDR_W-1:0] if_addr,
   output logic [DATA_W-1:0] if_inst,
   output logic              if_valid,
   output logic              stallreq_if,
   input  logic              dbg_req,
   input  logic              dbg_we,
   input  logic [ADDR_W-1:0] dbg_addr,
   input  logic [DATA_W-1:0] dbg_wdata,
   output logic              dbg_gnt,
   output logic [DATA_W-1:0] dbg_rdata,
   output logic              dbg_rvalid,
   output logic              mem_ce,
   output logic              mem_we,
   output logic [ADDR_W-1:0] mem_addr,
   output logic [DATA_W-1:0] mem_wdata,
   input  logic [DATA_W-1:0] mem_rdata
);

   localparam int unsigned CntW = $clog2(STARVE_LIM + 1);

   logic [CntW-1:0] starve_cnt_q, starve_cnt_d;
   rsp_owner_e      rsp_owner_q, rsp_owner_d;
   logic            grant_dbg, grant_if;

   always_comb begin
      grant_dbg   = 1'b0;
      grant_if    = 1'b0;
      if (rst != RstEnable) begin
         grant_dbg = dbg_req & (~if_ce | (starve_cnt_q == CntW'(STARVE_LIM)));
         grant_if  = if_ce & ~grant_dbg;
      end
      dbg_gnt     = grant_dbg;
      // Held low during reset so ctrl does not see a stall from a dead bus.
      stallreq_if = (rst != RstEnable) & if_ce & ~grant_if;
   end

   always_comb begin
      mem_ce    = ChipDisable;
      mem_we    = 1'b0;
      mem_addr  = '0;
      mem_wdata = '0;
      if (grant_if) begin
         mem_ce   = ChipEnable;
         mem_addr = if_addr;
      end else if (grant_dbg) begin
         mem_ce    = ChipEnable;
         mem_we    = dbg_we;
         mem_addr  = dbg_addr;
         mem_wdata = dbg_wdata;
      end
   end

   always_comb begin
      starve_cnt_d = starve_cnt_q;
      if (grant_dbg || !dbg_req) begin
         starve_cnt_d = '0;
      end else if (starve_cnt_q != CntW'(STARVE_LIM)) begin
         starve_cnt_d = starve_cnt_q + 1'b1;
      end

      rsp_owner_d = RspNone;
      if (grant_if) begin
         rsp_owner_d = RspIf;
      end else if (grant_dbg && !dbg_we) begin
         rsp_owner_d = RspDbg;
      end
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         starve_cnt_q <= '0;
         rsp_owner_q  <= RspNone;
      end else begin
         starve_cnt_q <= starve_cnt_d;
         rsp_owner_q  <= rsp_owner_d;
      end
   end

   always_comb begin
      if_valid   = (rsp_owner_q == RspIf);
      dbg_rvalid = (rsp_owner_q == RspDbg);
      if_inst    = if_valid ? mem_rdata : '0;
      dbg_rdata  = dbg_rvalid ? mem_rdata : '0;
   end

endmodule

// File: doc/inst_bus_arbiter.md
Name: inst_bus_arbiter

Overview:
- Shares the single-ported instruction memory between two requesters.
- Requester 0 is the pipeline fetch path (PC stage).
- Requester 1 is the debug/loader port, which reads or writes instruction words, for example to load a program or patch code at run time.
- Sits between the pc_reg/if_id path, the debug loader and the instruction memory. Raises a fetch stall request to ctrl whenever the fetch access is not granted.

Parameters:
- ADDR_W, 32, byte address width (matches InstAddrBus).
- DATA_W, 32, instruction word width (matches InstBus).
- STARVE_LIM, 4, consecutive cycles a pending debug request may lose before it is forced a grant.

Ports:
- clk  in  1  system clock.
- rst  in  1  asynchronous, active-high reset.
- if_ce  in  1  fetch request (ChipEnable level).
- if_addr  in  ADDR_W  fetch byte address.
- if_inst  out  DATA_W  fetched instruction.
- if_valid  out  1  if_inst valid this cycle.
- stallreq_if  out  1  fetch not granted this cycle; goes to ctrl.
- dbg_req  in  1  debug access request; held until dbg_gnt.
- dbg_we  in  1  1 = write, 0 = read.
- dbg_addr  in  ADDR_W  debug byte address.
- dbg_wdata  in  DATA_W  debug write data.
- dbg_gnt  out  1  debug access accepted this cycle.
- dbg_rdata  out  DATA_W  debug read data.
- dbg_rvalid  out  1  dbg_rdata valid this cycle.
- mem_ce  out  1  memory enable.
- mem_we  out  1  memory write enable.
- mem_addr  out  ADDR_W  memory byte address; the memory uses addr[.. : 2] as the word index.
- mem_wdata  out  DATA_W  memory write data.
- mem_rdata  in  DATA_W  memory read data; valid one cycle after a read with mem_ce=1.

Behaviour:
- Interface: clock clk, reset rst, asynchronous and active-high; single clock domain.
- Memory model: synchronous read with 1-cycle latency. A write completes at the clock edge where mem_ce=mem_we=1.

Grant (combinational, per cycle):
- grant_dbg = dbg_req & (~if_ce | starve_cnt == STARVE_LIM).
- grant_if = if_ce & ~grant_dbg.
- Fetch therefore has default priority.
- The two grants are mutually exclusive; neither is set when no request is pending.

Memory drive:
- grant_if: mem_ce=1, mem_we=0, mem_addr=if_addr, mem_wdata=0.
- grant_dbg: mem_ce=1, mem_we=dbg_we, mem_addr=dbg_addr, mem_wdata=dbg_wdata.
- No grant: mem_ce=0, mem_we=0, mem_addr=0, mem_wdata=0.

Handshake outputs:
- dbg_gnt = grant_dbg.
- stallreq_if = if_ce & ~grant_if.

Starvation counter starve_cnt (width clog2(STARVE_LIM+1)):
- Increments when dbg_req & ~grant_dbg.
- Clears when grant_dbg or ~dbg_req.
- Saturates at STARVE_LIM.

Response owner register rsp_owner, states NONE / IF / DBG, updated every edge:
- IF if grant_if.
- DBG if grant_dbg & ~dbg_we.
- Otherwise NONE; debug writes produce no response.

Response outputs (combinational from rsp_owner):
- if_valid = (rsp_owner == IF); if_inst = mem_rdata when if_valid, else ZeroWord.
- dbg_rvalid = (rsp_owner == DBG); dbg_rdata = mem_rdata when dbg_rvalid, else ZeroWord.

Latency:
- Fetch: request at cycle N with grant gives data at N+1.
- Debug read: granted at cycle G gives data at G+1.
- Back-to-back grants are allowed, so throughput is 1 access per cycle.

Reset:
- Async assertion clears rsp_owner to NONE and starve_cnt to 0.
- While rst=1, all grants are forced to 0. Result: all outputs 0/ZeroWord and stallreq_if=0.
- A response in flight when reset asserts is dropped.

Boundary conditions:
- Simultaneous if_ce and dbg_req with starve_cnt < STARVE_LIM: fetch wins, debug counts up.
- dbg_req deasserted before grant: counter clears, no access.
- Debug write and fetch to the same address: order is set by the grant. A fetch granted after the write edge reads the new data.
- Addresses are passed through unchanged; misalignment is not checked.

Decomposition:
- Existing defines (InstAddrBus, InstBus, ZeroWord, ChipEnable/ChipDisable, RstEnable) come from the shared defines file.
- Add to the shared defines: RspNone/RspIf/RspDbg 2-bit encodings, and DbgStarveLim default value.
- No sub-module: grant logic, counter and owner register stay in one module.

Test Plan:
- Fetch only: if_ce=1, addr 0x0, 0x4, 0x8 on consecutive cycles -> mem_ce=1 each cycle; if_valid=1 one cycle later with the mem words in order; stallreq_if=0 throughout.
- Debug read, fetch idle: dbg_req=1, we=0, addr 0x10 -> dbg_gnt=1 same cycle; next cycle dbg_rvalid=1, dbg_rdata=mem[4].
- Contention, STARVE_LIM=4: if_ce and dbg_req held high -> 4 fetch grants; 5th cycle dbg_gnt=1 and stallreq_if=1; counter back to 0; fetch resumes next cycle.
- Write then fetch: debug write 0xDEADBEEF to 0x20 with if_ce=0, then fetch 0x20 -> no dbg_rvalid; if_inst=0xDEADBEEF one cycle after the fetch grant.
- Reset mid-access: assert rst asynchronously between edges while a fetch is pending -> if_valid, dbg_rvalid, mem_ce and stallreq_if go to 0 immediately; after release, first fetch has 1-cycle latency.
- Request withdrawal: dbg_req high 2 losing cycles, then low -> starve_cnt returns to 0; no dbg_gnt, no memory write.
